// File: rtl/pulse_capture_la.sv
// pulse_capture_la: measures high/low intervals of a pulse line and queues
// {level, width} records in a show-ahead FIFO drained by a pop strobe.
//
// Ports:
//   wb_clk_i    system clock, all logic on the rising edge
//   wb_rst_i    synchronous active-high reset
//   pulse_i     pulse line under test
//   arm_i       level; rising edge flushes and starts capture, low aborts
//   rd_i        pop strobe, one record per cycle while valid_o=1
//   data_o      FIFO head: [CNT_W] = level that ended, [CNT_W-1:0] = width
//   valid_o     FIFO not empty
//   busy_o      capture in progress (WAIT_EDGE or MEASURE)
//   overflow_o  sticky; a record was dropped on a full FIFO
//   done_o      MAX_REC records produced since the last arm
//
// Build option: define PULSE_CAPTURE_SYNC_EN to put a 2-flop synchronizer
// on pulse_i (one extra cycle of latency, same recorded widths).

module pulse_capture_la #(
    parameter int CNT_W   = 16,
    parameter int DEPTH   = 8,
    parameter int MAX_REC = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             pulse_i,
    input  logic             arm_i,
    input  logic             rd_i,
    output logic [CNT_W:0]   data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             overflow_o,
    output logic             done_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int REC_W = (MAX_REC > 1) ? $clog2(MAX_REC + 1) : 1;
    localparam logic [REC_W-1:0] REC_LAST =
        REC_W'((MAX_REC > 0) ? MAX_REC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_t;

    state_t            state;
    logic              p_s;
    logic              p_d;
    logic              arm_q;
    logic [CNT_W-1:0]  cnt;
    logic [REC_W-1:0]  rec_cnt;
    logic [CNT_W:0]    mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     fill;

    logic edge_det;
    logic arm_rise;
    logic push_req;
    logic full;
    logic pop;
    logic do_push;
    logic drop;

    // Input sampling; p_s is the last flop of the sampling path.
`ifdef PULSE_CAPTURE_SYNC_EN
    logic sync1;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1 <= 1'b0;
            p_s   <= 1'b0;
        end else begin
            sync1 <= pulse_i;
            p_s   <= sync1;
        end
    end
`else
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) p_s <= 1'b0;
        else          p_s <= pulse_i;
    end
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            p_d   <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            p_d   <= p_s;
            arm_q <= arm_i;
        end
    end

    assign edge_det = p_s ^ p_d;
    assign arm_rise = arm_i & ~arm_q;

    // An abort (arm_i low) in the same cycle as an edge wins over the push.
    assign push_req = (state == MEASURE) & edge_det & arm_i;

    assign fill    = wr_ptr - rd_ptr;
    assign full    = (fill == PW'(DEPTH));
    assign valid_o = (wr_ptr != rd_ptr);
    assign pop     = rd_i & valid_o;
    // A pop frees the slot the simultaneous push needs.
    assign do_push = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    assign data_o = valid_o ? mem[rd_ptr[AW-1:0]] : '0;
    assign busy_o = (state != IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            rec_cnt <= '0;
            done_o  <= 1'b0;
        end else if (arm_rise) begin
            state   <= WAIT_EDGE;
            cnt     <= '0;
            rec_cnt <= '0;
            done_o  <= 1'b0;
        end else if (!arm_i && state != IDLE) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: ;
                WAIT_EDGE: begin
                    // The partial interval before the first edge is dropped.
                    if (edge_det) begin
                        cnt   <= CNT_W'(1);
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        cnt     <= CNT_W'(1);
                        rec_cnt <= rec_cnt + 1'b1;
                        if (MAX_REC != 0 && rec_cnt == REC_LAST) begin
                            done_o <= 1'b1;
                            state  <= IDLE;
                        end
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else if (arm_rise) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop)    overflow_o <= 1'b1;
        end
    end

    // Record stores the level that just ended, hence ~p_s.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {~p_s, cnt};
    end

endmodule

// File: tb/tb_pulse_capture_la.sv
// tb_pulse_capture_la: directed checks of pulse_capture_la, one instance with
// default parameters and one with CNT_W=4, MAX_REC=3.

module tb_pulse_capture_la;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse, arm, rd;
    logic [16:0] data;
    logic        valid, busy, ovf, done;
    logic        pulse2, arm2, rd2;
    logic [4:0]  data2;
    logic        valid2, busy2, ovf2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_capture_la dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .pulse_i    (pulse),
        .arm_i      (arm),
        .rd_i       (rd),
        .data_o     (data),
        .valid_o    (valid),
        .busy_o     (busy),
        .overflow_o (ovf),
        .done_o     (done)
    );

    pulse_capture_la #(.CNT_W(4), .DEPTH(8), .MAX_REC(3)) dut2 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .pulse_i    (pulse2),
        .arm_i      (arm2),
        .rd_i       (rd2),
        .data_o     (data2),
        .valid_o    (valid2),
        .busy_o     (busy2),
        .overflow_o (ovf2),
        .done_o     (done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_a(input string tag, input logic [16:0] exp);
        chk({tag, " valid"}, 32'(valid), 32'd1);
        chk(tag, 32'(data), 32'(exp));
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic pop_b(input string tag, input logic [4:0] exp);
        chk({tag, " valid"}, 32'(valid2), 32'd1);
        chk(tag, 32'(data2), 32'(exp));
        rd2 = 1'b1;
        tick();
        rd2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pulse = 1'b0; arm = 1'b0; rd = 1'b0;
        pulse2 = 1'b0; arm2 = 1'b0; rd2 = 1'b0;
        ticks(2);
        chk("rst valid", 32'(valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst ovf", 32'(ovf), 0);
        chk("rst done", 32'(done), 0);
        chk("rst data", 32'(data), 0);
        chk("rst b data", 32'(data2), 0);
        rst = 1'b0;

        // Unarmed: edges on pulse_i must be ignored.
        for (int i = 0; i < 6; i++) begin
            pulse = ~pulse;
            tick();
        end
        pulse = 1'b0;
        ticks(4);
        chk("idle valid", 32'(valid), 0);
        chk("idle busy", 32'(busy), 0);

        // Square wave: high 5 / low 3, three periods, then high.
        arm = 1'b1;
        tick();
        chk("sq busy", 32'(busy), 1);
        ticks(2);
        for (int p = 0; p < 3; p++) begin
            pulse = 1'b1; ticks(5);
            pulse = 1'b0; ticks(3);
        end
        pulse = 1'b1;
        ticks(5);
        chk("sq ovf", 32'(ovf), 0);
        chk("sq done", 32'(done), 0);
        for (int i = 0; i < 6; i++)
            pop_a($sformatf("sq rec%0d", i),
                  (i % 2 == 0) ? 17'h10005 : 17'h00003);
        chk("sq empty", 32'(valid), 0);

        // Overflow: 1-cycle toggling, 13 records into an 8-deep FIFO.
        arm = 1'b0; tick();
        arm = 1'b1; tick();
        for (int i = 0; i < 14; i++) begin
            pulse = ~pulse;
            tick();
        end
        ticks(4);
        chk("ovf flag", 32'(ovf), 1);
        for (int i = 0; i < 8; i++)
            pop_a($sformatf("ovf rec%0d", i), {1'(i % 2), 16'd1});
        chk("ovf empty", 32'(valid), 0);
        rd = 1'b1; tick(); rd = 1'b0;
        chk("rd empty ignored", 32'(valid), 0);

        // Full FIFO with push and pop in the same cycle.
        arm = 1'b0; tick();
        arm = 1'b1; tick();
        chk("rearm ovf clr", 32'(ovf), 0);
        chk("rearm empty", 32'(valid), 0);
        for (int i = 0; i < 9; i++) begin
            pulse = ~pulse;
            tick();
        end
        ticks(3);
        chk("full ovf", 32'(ovf), 0);
        pulse = 1'b1;
        tick();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("pp ovf", 32'(ovf), 0);
        for (int i = 1; i < 8; i++)
            pop_a($sformatf("pp rec%0d", i), {1'(i % 2), 16'd1});
        pop_a("pp new", 17'h00004);
        chk("pp empty", 32'(valid), 0);

        // Abort keeps FIFO contents; re-arm flushes.
        pulse = 1'b0;
        ticks(4);
        chk("abort pre valid", 32'(valid), 1);
        arm = 1'b0;
        tick();
        chk("abort busy", 32'(busy), 0);
        ticks(2);
        chk("abort kept", 32'(valid), 1);
        arm = 1'b1;
        tick();
        chk("rearm flush", 32'(valid), 0);
        chk("rearm busy", 32'(busy), 1);
        arm = 1'b0;
        tick();

        // Saturation and auto-stop on the 4-bit, 3-record instance.
        arm2 = 1'b1;
        ticks(2);
        pulse2 = 1'b1; ticks(40);
        pulse2 = 1'b0; ticks(3);
        pulse2 = 1'b1; ticks(2);
        chk("b done early", 32'(done2), 0);
        chk("b busy early", 32'(busy2), 1);
        pulse2 = 1'b0;
        ticks(4);
        chk("b done", 32'(done2), 1);
        chk("b busy", 32'(busy2), 0);
        chk("b ovf", 32'(ovf2), 0);
        pop_b("b sat", 5'h1F);
        pop_b("b rec1", 5'h03);
        pop_b("b rec2", 5'h12);
        chk("b empty", 32'(valid2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
